contact_detector: RTL and testbench
===================================

Name: contact_detector

Overview:
- Upstream feeder of the point/score judge: converts ball and blob positions into the `gnd_col`, `collisionsplayer1` and `collisionsplayer2` signals the judge consumes.
- Runs a 3-stage registered distance pipeline per player (circle vs circle) and a delay-matched ground test.
- Produces one-cycle touch pulses with re-arm and hold-off, plus a level ground-contact flag.
- Sits between the position/physics logic and the judge, in the 65 MHz pixel-clock domain.

Parameters:
- BALL_R, 20, ball radius in pixels.
- PLAYER_R, 40, blob radius in pixels.
- GROUND_Y, 750, y coordinate of the floor line.
- HOLDOFF, 650_000, pulse suppression window per player in clk cycles (10 ms at 65 MHz).

Ports:
- clk  in  1  system clock, 65 MHz.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- xposball  in  12  ball centre x, unsigned pixels.
- yposball  in  12  ball centre y, unsigned pixels (y grows downward).
- xpos_p1, ypos_p1  in  12 each  player-1 blob centre.
- xpos_p2, ypos_p2  in  12 each  player-2 blob centre.
- gnd_col  out  1  level: ball touching or below the floor.
- collisionsplayer1  out  1  one-cycle touch pulse, player 1.
- collisionsplayer2  out  1  one-cycle touch pulse, player 2.
- overlap_p1  out  1  level: ball currently overlaps player 1 (for physics).
- overlap_p2  out  1  level: ball currently overlaps player 2.

Behaviour:
- Reset (rst=0, async): all pipeline registers, outputs and hold-off counters go to 0. Re-arm flags go to 0 (disarmed).
  - Consequence: an overlap already present when reset releases gives no pulse until it has first cleared.
- Pipeline stage 1 (edge E): dx = xposball − xpos_pN and dy = yposball − ypos_pN, signed 13 bit. Also gsum = yposball + BALL_R, 13 bit unsigned, no wrap.
- Pipeline stage 2 (E+1): dx², dy², unsigned 26 bit.
- Pipeline stage 3 (E+2): overlap_pN = (dx² + dy², 27 bit) ≤ (BALL_R+PLAYER_R)², a compile-time constant. Tangency counts as overlap. gnd = gsum ≥ GROUND_Y.
- Output stage (E+3): overlap_pN, gnd_col and pulses become visible.
  - Latency is 3 edges after input capture for every output; all outputs stay mutually aligned.
- gnd_col: registered copy of the stage-3 ground compare, held as a level for as long as the condition holds. The judge samples it on two consecutive cycles, so it must not be pulsed.
- Per-player pulse logic. Per player: armed flag plus hold-off counter, ceil(log2(HOLDOFF+1)) bits.
  - Pulse rule: collisionsplayerN = 1 for exactly one cycle when stage-3 overlap=1 AND armed=1 AND counter=0.
  - On a pulse: armed←0 and counter←HOLDOFF.
  - Counter decrements to 0 each cycle and saturates at 0.
  - armed←1 on any cycle where stage-3 overlap=0. Re-arm is independent of the counter.
  - Overlap persisting past hold-off gives no second pulse. Leaving and re-entering within hold-off gives no pulse. Re-entering after counter=0 and a re-arm gives a pulse.
- Both players are independent: simultaneous pulses on the same cycle are legal and both are emitted.
- Inputs are not required to be stable; any cycle-to-cycle change simply propagates through the pipeline.
- Extremes: x = 0 vs 4095 gives |dx| = 4095, dx² = 16,769,025. The 27-bit sum never overflows.
- Reset mid-operation: in-flight pipeline results are discarded, no pulse is emitted from them, and counters are cleared.

Test Plan:
- Reset then idle: ball (100,100), p1 (500,600), p2 (900,600) → all outputs 0 for 1000 cycles. After rst deasserts, the first output change happens no earlier than 3 edges later.
- Entry pulse:
  - Stimulus: from armed, no-overlap state, set p1 to (150,100), giving dist² = 2500 ≤ 3600, at edge E.
  - Required: overlap_p1=1 and collisionsplayer1=1 after edge E+3; collisionsplayer1=0 from E+4. overlap_p1 stays 1.
- Tangency and boundary:
  - p1 at (160,100), dist² = 3600 → pulse.
  - p1 at (161,100), dist² = 3721 → no pulse, overlap_p1=0.
  - yposball = 730 → gnd_col=1 at E+3.
  - yposball = 729 → gnd_col=0.
- Hold-off:
  - Stimulus: with HOLDOFF overridden to 100, pulse at cycle T, leave overlap at T+10, re-enter at T+50.
  - Required: no pulse on re-entry.
  - Stimulus: leave again, then re-enter at T+200.
  - Required: exactly one pulse, 3 edges after re-entry.
- Simultaneous: ball (500,100), p1 (460,100), p2 (540,100), both entered on the same edge → collisionsplayer1 and collisionsplayer2 pulse on the same cycle.
- Reset with overlap held: assert rst while p1 overlaps, release with overlap still held → no pulse. Move p1 away for 1 cycle and back → one pulse.

Source files
------------

// File: rtl/contact_detector.sv
// Purpose: ball/blob circle overlap and floor contact detector feeding the point judge.
// Latency: 3 clk edges from input capture to every output, all outputs mutually aligned.
// Backpressure: none; free-running pipeline that accepts new positions every cycle.
module contact_detector #(
  parameter int BALL_R   = 20,
  parameter int PLAYER_R = 40,
  parameter int GROUND_Y = 750,
  parameter int HOLDOFF  = 650_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xposball,
  input  logic [11:0] yposball,
  input  logic [11:0] xpos_p1,
  input  logic [11:0] ypos_p1,
  input  logic [11:0] xpos_p2,
  input  logic [11:0] ypos_p2,
  output logic        gnd_col,
  output logic        collisionsplayer1,
  output logic        collisionsplayer2,
  output logic        overlap_p1,
  output logic        overlap_p2
);

  // Hold-off counter width; a zero hold-off still needs a 1-bit counter.
  localparam int CW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  // Squared sum of radii: touching circles (equality) count as overlap.
  localparam logic [26:0]   R2_LIM = 27'((BALL_R + PLAYER_R) * (BALL_R + PLAYER_R));
  localparam logic [12:0]   GND_LIM = 13'(GROUND_Y);
  localparam logic [12:0]   BALL_R_W = 13'(BALL_R);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF);

  // Per-player position buses so both players share one generate body (index 0 = p1).
  logic [1:0][11:0] xp;
  logic [1:0][11:0] yp;
  assign xp = {xpos_p2, xpos_p1};
  assign yp = {ypos_p2, ypos_p1};

  // Pipeline occupancy: stages are only trusted once real inputs have reached them,
  // so reset-cleared registers (which look like zero distance) never raise overlap
  // and never re-arm the pulse logic.
  logic v1;
  logic v2;
  logic v3;

  // Valid chain that fills after reset release and empties on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= 1'b1;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Floor path, delay-matched to the distance pipeline.
  logic [12:0] s1_gsum;
  logic [12:0] s2_gsum;
  logic        s3_gnd;

  // Ball bottom edge, carried through two stages, compared, then registered out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_gsum <= '0;
      s2_gsum <= '0;
      s3_gnd  <= 1'b0;
      gnd_col <= 1'b0;
    end else begin
      s1_gsum <= {1'b0, yposball} + BALL_R_W;
      s2_gsum <= s1_gsum;
      s3_gnd  <= v2 && (s2_gsum >= GND_LIM);
      gnd_col <= s3_gnd;
    end
  end

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_pl
      logic signed [12:0] s1_dx;
      logic signed [12:0] s1_dy;
      logic        [12:0] abs_dx;
      logic        [12:0] abs_dy;
      logic        [25:0] s2_dx2;
      logic        [25:0] s2_dy2;
      logic        [26:0] dist2;
      logic               s3_ovl;
      logic               ovl_q;
      logic               pulse_q;
      logic               armed;
      logic        [CW-1:0] cnt;
      logic               fire;

      // Magnitudes of the signed deltas; |delta| never exceeds 4095 so 13 bits hold it.
      always_comb begin
        abs_dx = s1_dx[12] ? (~$unsigned(s1_dx) + 13'd1) : $unsigned(s1_dx);
        abs_dy = s1_dy[12] ? (~$unsigned(s1_dy) + 13'd1) : $unsigned(s1_dy);
        dist2  = 27'(s2_dx2) + 27'(s2_dy2);
        fire   = s3_ovl && armed && (cnt == '0);
      end

      // Distance pipeline: deltas, squares, threshold compare.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          s1_dx  <= '0;
          s1_dy  <= '0;
          s2_dx2 <= '0;
          s2_dy2 <= '0;
          s3_ovl <= 1'b0;
        end else begin
          s1_dx  <= $signed({1'b0, xposball}) - $signed({1'b0, xp[p]});
          s1_dy  <= $signed({1'b0, yposball}) - $signed({1'b0, yp[p]});
          s2_dx2 <= 26'(abs_dx) * 26'(abs_dx);
          s2_dy2 <= 26'(abs_dy) * 26'(abs_dy);
          s3_ovl <= v2 && (dist2 <= R2_LIM);
        end
      end

      // Output stage: overlap level, one-shot touch pulse, re-arm and hold-off.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ovl_q   <= 1'b0;
          pulse_q <= 1'b0;
          armed   <= 1'b0;
          cnt     <= '0;
        end else begin
          ovl_q   <= s3_ovl;
          pulse_q <= fire;
          if (fire) begin
            armed <= 1'b0;
            cnt   <= HOLD_LD;
          end else begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end
            // Arming needs a genuine no-overlap sample, not an empty pipeline.
            if (v3 && !s3_ovl) begin
              armed <= 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  assign overlap_p1        = g_pl[0].ovl_q;
  assign overlap_p2        = g_pl[1].ovl_q;
  assign collisionsplayer1 = g_pl[0].pulse_q;
  assign collisionsplayer2 = g_pl[1].pulse_q;

endmodule

// File: tb/tb_contact_detector.sv
module tb_contact_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xb, yb, x1, y1, x2, y2;
  logic        gnd_col, collisionsplayer1, collisionsplayer2, overlap_p1, overlap_p2;

  always #5 clk = ~clk;

  contact_detector #(.HOLDOFF(100)) dut (
    .clk(clk),
    .rst(rst),
    .xposball(xb),
    .yposball(yb),
    .xpos_p1(x1),
    .ypos_p1(y1),
    .xpos_p2(x2),
    .ypos_p2(y2),
    .gnd_col(gnd_col),
    .collisionsplayer1(collisionsplayer1),
    .collisionsplayer2(collisionsplayer2),
    .overlap_p1(overlap_p1),
    .overlap_p2(overlap_p2)
  );

  int total = 0;
  int bad   = 0;
  int n1    = 0;
  int n2    = 0;

  // Scoreboard entries: {gnd, pulse1, pulse2, ovl1, ovl2}
  logic [4:0] q[$];
  bit         m_arm[2];
  int         m_cnt[2];

  function automatic bit ovl(int bx, int by, int px, int py);
    int dx;
    int dy;
    dx = bx - px;
    dy = by - py;
    return (dx * dx + dy * dy) <= 3600;
  endfunction

  task automatic chk(string tag, logic got, logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    total++;
    assert (got == exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic zero_check(string tag);
    chk({tag, "_gnd"}, gnd_col, 1'b0);
    chk({tag, "_c1"}, collisionsplayer1, 1'b0);
    chk({tag, "_c2"}, collisionsplayer2, 1'b0);
    chk({tag, "_o1"}, overlap_p1, 1'b0);
    chk({tag, "_o2"}, overlap_p2, 1'b0);
  endtask

  // One clock: predict the result of the current inputs, clock, compare the
  // result predicted three edges earlier.
  task automatic step();
    bit         o[2];
    bit         pl[2];
    bit         g;
    logic [4:0] e;
    o[0] = ovl(int'(xb), int'(yb), int'(x1), int'(y1));
    o[1] = ovl(int'(xb), int'(yb), int'(x2), int'(y2));
    g    = (int'(yb) + 20) >= 750;
    for (int i = 0; i < 2; i++) begin
      pl[i] = o[i] && m_arm[i] && (m_cnt[i] == 0);
      if (pl[i]) begin
        m_arm[i] = 1'b0;
        m_cnt[i] = 100;
      end else begin
        if (m_cnt[i] > 0) m_cnt[i]--;
        if (!o[i]) m_arm[i] = 1'b1;
      end
    end
    q.push_back({g, pl[0], pl[1], o[0], o[1]});
    @(posedge clk);
    #1;
    if (q.size() == 4) begin
      e = q.pop_front();
      chk("gnd_col", gnd_col, e[4]);
      chk("pulse_p1", collisionsplayer1, e[3]);
      chk("pulse_p2", collisionsplayer2, e[2]);
      chk("overlap_p1", overlap_p1, e[1]);
      chk("overlap_p2", overlap_p2, e[0]);
    end
    if (collisionsplayer1) n1++;
    if (collisionsplayer2) n2++;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  // Async reset: outputs must clear immediately and stay clear through release
  // plus the three-edge pipeline refill.
  task automatic do_reset(int n);
    rst = 1'b0;
    #1;
    zero_check("rst_async");
    q.delete();
    m_arm[0] = 1'b0;
    m_arm[1] = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    repeat (n) @(posedge clk);
    #1;
    zero_check("rst_held");
    rst = 1'b1;
    repeat (3) q.push_back(5'b0);
  endtask

  initial begin
    xb = 12'd100; yb = 12'd100;
    x1 = 12'd500; y1 = 12'd600;
    x2 = 12'd900; y2 = 12'd600;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset(4);

    // Idle, nothing touching
    run(1000);

    // Entry pulse at distance 50
    x1 = 12'd150; y1 = 12'd100; run(10);
    x1 = 12'd500; y1 = 12'd600; run(120);

    // Tangency (60) pulses, one pixel further does not
    x1 = 12'd160; y1 = 12'd100; run(10);
    x1 = 12'd500; y1 = 12'd600; run(120);
    x1 = 12'd161; y1 = 12'd100; run(10);
    x1 = 12'd500; y1 = 12'd600; run(20);

    // Floor boundary
    yb = 12'd730; run(8);
    yb = 12'd729; run(8);
    yb = 12'd100; run(110);

    // Hold-off: pulse, leave at +10, re-enter at +50, leave at +70, re-enter at +200
    x1 = 12'd150; y1 = 12'd100; run(10);
    x1 = 12'd500; y1 = 12'd600; run(40);
    x1 = 12'd150; y1 = 12'd100; run(20);
    x1 = 12'd500; y1 = 12'd600; run(130);
    x1 = 12'd150; y1 = 12'd100; run(10);
    x1 = 12'd500; y1 = 12'd600; run(120);

    // Coordinate extremes
    xb = 12'd0;    x1 = 12'd4095; y1 = 12'd100; run(6);
    xb = 12'd4095; x1 = 12'd0;                  run(6);

    // Simultaneous entry on both players
    xb = 12'd500; yb = 12'd100;
    x1 = 12'd500; y1 = 12'd600;
    x2 = 12'd900; y2 = 12'd600;
    run(10);
    x1 = 12'd460; y1 = 12'd100;
    x2 = 12'd540; y2 = 12'd100;
    run(10);

    // Reset while overlapping: no pulse until the overlap has cleared once
    do_reset(3);
    run(20);
    x1 = 12'd500; y1 = 12'd600; run(1);
    x1 = 12'd460; y1 = 12'd100; run(10);
    run(3);

    // Hand-counted touch pulses over the whole run
    chk_int("pulse_count_p1", n1, 6);
    chk_int("pulse_count_p2", n2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
